pc_ctx_seq: RTL

//  Multi-context program-counter sequencer for the pipelined MIPS fetch stage.

---
 rtl/pcs_pkg.sv | 21 ++
 rtl/pcs_rr_arb.sv | 33 +++
 rtl/pc_ctx_seq.sv | 122 ++++++++++++
 3 files changed

// File: rtl/pcs_pkg.sv
// Shared definitions for the multi-context PC sequencer.
// Latency: n/a (types, constants and a width helper only).
// Backpressure: n/a.
package pcs_pkg;

  // Default geometry and vectors for a four-context MIPS fetch front end.
  localparam int          PCS_NUM_CTX_DEF   = 4;
  localparam logic [31:0] PCS_RESET_VEC_DEF = 32'h0000_0000;
  localparam logic [31:0] PCS_EXC_VEC_DEF   = 32'h8000_0180;

  // Context-id width; a single-context build still needs a 1-bit id port.
  function automatic int pcs_ctx_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  localparam int PCS_CTX_W_DEF = pcs_ctx_w(PCS_NUM_CTX_DEF);

  // Context id for the default geometry.
  typedef logic [PCS_CTX_W_DEF-1:0] pcs_ctx_t;

endpackage

// File: rtl/pcs_rr_arb.sv
// Round-robin picker over the active-context mask, searching from ptr+1.
// Latency: purely combinational.
// Backpressure: none; any=0 when no context requests.
// Ports: req (per-context request mask), ptr (last granted context),
//        sel (granted context), any (a grant exists).
module pcs_rr_arb
  import pcs_pkg::*;
#(
  parameter int NUM_CTX = 4,
  localparam int CTX_W  = pcs_ctx_w(NUM_CTX)
) (
  input  logic [NUM_CTX-1:0] req,
  input  logic [CTX_W-1:0]   ptr,
  output logic [CTX_W-1:0]   sel,
  output logic               any
);

  // Offsets 1..NUM_CTX: the last-granted context is considered last, so
  // a lone active context still wins every cycle.
  always_comb begin
    sel = '0;
    any = 1'b0;
    for (int i = 1; i <= NUM_CTX; i++) begin : g_search
      int idx;
      idx = (int'(ptr) + i) % NUM_CTX;
      if (!any && req[idx]) begin
        any = 1'b1;
        sel = CTX_W'(idx);
      end
    end
  end

endmodule

// File: rtl/pc_ctx_seq.sv
// Multi-context PC sequencer: issues one fetch PC per cycle round-robin over active contexts.
// Latency: 1 cycle from arbitration to registered PCS_PC_OUT/PCS_CTX_OUT/PCS_VALID_OUT.
// Backpressure: PCS_EN=0 freezes outputs, pointer and increments; redirects still land.
// Ports: PCS_CLK/PCS_RST (sync, active-high); PCS_EN issue enable; PCS_CTX_ACT active mask;
//        PCS_REDIR_* branch/jump redirect; PCS_PC_OUT/PCS_CTX_OUT/PCS_VALID_OUT issued fetch.
// Optional macro PCS_EXC_EN adds PCS_EXC_VALID/CTX/PC exception redirect, per-context EPC
// registers and the combinational EPC read port PCS_EPC_CTX -> PCS_EPC_OUT.
module pc_ctx_seq
  import pcs_pkg::*;
#(
  parameter int               WIDTH     = 32,
  parameter int               NUM_CTX   = PCS_NUM_CTX_DEF,
  parameter int               INC       = 4,
  parameter logic [WIDTH-1:0] RESET_VEC = PCS_RESET_VEC_DEF,
  parameter logic [WIDTH-1:0] EXC_VEC   = PCS_EXC_VEC_DEF,
  localparam int              CTX_W     = pcs_ctx_w(NUM_CTX)
) (
  input  logic               PCS_CLK,
  input  logic               PCS_RST,
  input  logic               PCS_EN,
  input  logic [NUM_CTX-1:0] PCS_CTX_ACT,
  input  logic               PCS_REDIR_VALID,
  input  logic [CTX_W-1:0]   PCS_REDIR_CTX,
  input  logic [WIDTH-1:0]   PCS_REDIR_PC,
`ifdef PCS_EXC_EN
  input  logic               PCS_EXC_VALID,
  input  logic [CTX_W-1:0]   PCS_EXC_CTX,
  input  logic [WIDTH-1:0]   PCS_EXC_PC,
  input  logic [CTX_W-1:0]   PCS_EPC_CTX,
  output logic [WIDTH-1:0]   PCS_EPC_OUT,
`endif
  output logic [WIDTH-1:0]   PCS_PC_OUT,
  output logic [CTX_W-1:0]   PCS_CTX_OUT,
  output logic               PCS_VALID_OUT
);

  logic [WIDTH-1:0]   pc_q [NUM_CTX];
  logic [WIDTH-1:0]   pc_d [NUM_CTX];
  logic [CTX_W-1:0]   ptr_q;
  logic [CTX_W-1:0]   sel;
  logic               any;
  logic [NUM_CTX-1:0] redir_hit;
  logic [NUM_CTX-1:0] exc_hit;
  logic               cancel;
  logic               issue;

  pcs_rr_arb #(.NUM_CTX(NUM_CTX)) u_arb (
    .req (PCS_CTX_ACT),
    .ptr (ptr_q),
    .sel (sel),
    .any (any)
  );

  // Per-context decode; an out-of-range context id matches no slot and is dropped.
  always_comb begin
    redir_hit = '0;
    exc_hit   = '0;
    for (int c = 0; c < NUM_CTX; c++) begin
      redir_hit[c] = PCS_REDIR_VALID && (PCS_REDIR_CTX == CTX_W'(c));
`ifdef PCS_EXC_EN
      exc_hit[c]   = PCS_EXC_VALID && (PCS_EXC_CTX == CTX_W'(c));
`endif
    end
  end

  // A redirect or exception on the selected context kills this issue so the
  // context re-arbitrates next cycle from its new PC.
  assign cancel = redir_hit[sel] | exc_hit[sel];
  assign issue  = PCS_EN & any & ~cancel;

  // Exception beats redirect beats sequential increment.
  always_comb begin
    for (int c = 0; c < NUM_CTX; c++) begin
      pc_d[c] = pc_q[c];
      if (exc_hit[c])
        pc_d[c] = EXC_VEC;
      else if (redir_hit[c])
        pc_d[c] = PCS_REDIR_PC;
      else if (issue && (sel == CTX_W'(c)))
        pc_d[c] = pc_q[c] + WIDTH'(INC);
    end
  end

  always_ff @(posedge PCS_CLK) begin
    if (PCS_RST) begin
      for (int c = 0; c < NUM_CTX; c++) pc_q[c] <= RESET_VEC;
      ptr_q         <= CTX_W'(NUM_CTX - 1);
      PCS_PC_OUT    <= RESET_VEC;
      PCS_CTX_OUT   <= '0;
      PCS_VALID_OUT <= 1'b0;
    end else begin
      for (int c = 0; c < NUM_CTX; c++) pc_q[c] <= pc_d[c];
      if (PCS_EN) begin
        if (issue) begin
          PCS_PC_OUT    <= pc_q[sel];
          PCS_CTX_OUT   <= sel;
          PCS_VALID_OUT <= 1'b1;
          ptr_q         <= sel;
        end else begin
          // No candidate or cancelled: bubble, PC/ctx/pointer hold.
          PCS_VALID_OUT <= 1'b0;
        end
      end
    end
  end

`ifdef PCS_EXC_EN
  logic [WIDTH-1:0] epc_q [NUM_CTX];

  always_ff @(posedge PCS_CLK) begin
    if (PCS_RST) begin
      for (int c = 0; c < NUM_CTX; c++) epc_q[c] <= '0;
    end else begin
      for (int c = 0; c < NUM_CTX; c++)
        if (exc_hit[c]) epc_q[c] <= PCS_EXC_PC;
    end
  end

  assign PCS_EPC_OUT = (int'(PCS_EPC_CTX) < NUM_CTX) ? epc_q[PCS_EPC_CTX] : '0;
`endif

endmodule
